// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: DATA_WIDTH bits split into NUM_STAGES carry-registered chunks,
// with valid/ready flow control on both sides and one operation per cycle.
module pipelined_adder #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] X,
  input  logic [DATA_WIDTH-1:0] Y,
  input  logic                  MODE,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH:0]   SUM
);

  localparam int STAGES_SAFE = (NUM_STAGES < 1) ? 1 : NUM_STAGES;
  localparam int CHUNK       = DATA_WIDTH / STAGES_SAFE;

  if (NUM_STAGES < 1 || (DATA_WIDTH % STAGES_SAFE) != 0) begin : g_param_check
    $error("pipelined_adder: NUM_STAGES must be >= 1 and divide DATA_WIDTH");
  end

  logic advance;

  // Per-stage inputs: stage 0 sees the ports, stage k sees stage k-1's registers.
  logic [DATA_WIDTH-1:0] a_prev [STAGES_SAFE];
  logic [DATA_WIDTH-1:0] b_prev [STAGES_SAFE];
  logic [DATA_WIDTH-1:0] r_prev [STAGES_SAFE];
  logic [STAGES_SAFE-1:0] carry_prev;

  logic [DATA_WIDTH-1:0] a_d [STAGES_SAFE];
  logic [DATA_WIDTH-1:0] b_d [STAGES_SAFE];
  logic [DATA_WIDTH-1:0] r_d [STAGES_SAFE];
  logic [DATA_WIDTH-1:0] a_q [STAGES_SAFE];
  logic [DATA_WIDTH-1:0] b_q [STAGES_SAFE];
  logic [DATA_WIDTH-1:0] r_q [STAGES_SAFE];
  logic [STAGES_SAFE-1:0] carry_d, carry_q;
  logic [STAGES_SAFE-1:0] valid_d, valid_q;

  always_comb begin
    advance   = !OUT_VALID || OUT_READY;
    IN_READY  = advance;
    OUT_VALID = valid_q[STAGES_SAFE-1];
    SUM       = {carry_q[STAGES_SAFE-1], r_q[STAGES_SAFE-1]};
  end

  always_comb begin
    logic [CHUNK:0] chunk_sum;
    chunk_sum     = '0;
    carry_prev    = '0;
    valid_d       = '0;
    carry_d       = '0;
    a_prev[0]     = X;
    b_prev[0]     = MODE ? ~Y : Y;
    r_prev[0]     = '0;
    carry_prev[0] = MODE;
    valid_d[0]    = IN_VALID;
    for (int unsigned k = 1; k < STAGES_SAFE; k++) begin
      a_prev[k]     = a_q[k-1];
      b_prev[k]     = b_q[k-1];
      r_prev[k]     = r_q[k-1];
      carry_prev[k] = carry_q[k-1];
      valid_d[k]    = valid_q[k-1];
    end
    for (int unsigned k = 0; k < STAGES_SAFE; k++) begin
      chunk_sum = {1'b0, a_prev[k][k*CHUNK +: CHUNK]}
                + {1'b0, b_prev[k][k*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, carry_prev[k]};
      a_d[k]    = a_prev[k];
      b_d[k]    = b_prev[k];
      r_d[k]    = r_prev[k];
      r_d[k][k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      carry_d[k] = chunk_sum[CHUNK];
    end
  end

  // Data registers load only behind a valid op, so SUM keeps its last value across bubbles.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int unsigned k = 0; k < STAGES_SAFE; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      for (int unsigned k = 0; k < STAGES_SAFE; k++) begin
        if (valid_d[k]) begin
          a_q[k]     <= a_d[k];
          b_q[k]     <= b_d[k];
          r_q[k]     <= r_d[k];
          carry_q[k] <= carry_d[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: main 8-bit/2-stage instance plus a bank of
// 8- and 32-bit instances with 1, 2 and 4 stages for back-to-back streaming.
module tb_pipelined_adder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic       mode = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [8:0] sum;

  logic        bvalid = 1'b0;
  logic [31:0] bx = '0;
  logic [31:0] by = '0;
  logic        bmode = 1'b0;
  logic        r8 [3];
  logic        v8 [3];
  logic [8:0]  s8 [3];
  logic        r32 [3];
  logic        v32 [3];
  logic [32:0] s32 [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.DATA_WIDTH(8), .NUM_STAGES(2)) u_dut (
    .clock(clk), .reset(reset), .IN_VALID(in_valid), .IN_READY(in_ready),
    .X(x), .Y(y), .MODE(mode), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .SUM(sum)
  );

  for (genvar g = 0; g < 3; g++) begin : g_bank
    pipelined_adder #(.DATA_WIDTH(8), .NUM_STAGES(1 << g)) u_b8 (
      .clock(clk), .reset(reset), .IN_VALID(bvalid), .IN_READY(r8[g]),
      .X(bx[7:0]), .Y(by[7:0]), .MODE(bmode), .OUT_VALID(v8[g]), .OUT_READY(1'b1),
      .SUM(s8[g])
    );
    pipelined_adder #(.DATA_WIDTH(32), .NUM_STAGES(1 << g)) u_b32 (
      .clock(clk), .reset(reset), .IN_VALID(bvalid), .IN_READY(r32[g]),
      .X(bx), .Y(by), .MODE(bmode), .OUT_VALID(v32[g]), .OUT_READY(1'b1),
      .SUM(s32[g])
    );
  end

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_cmp++;
    if (sum !== 9'h000) begin
      n_err++; $display("FAIL reset_sum: got %h expected 000", sum);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  // Single isolated ops: latency of 2 edges and OUT_VALID for exactly one cycle.
  task automatic test_single_ops();
    logic [7:0] vx [6];
    logic [7:0] vy [6];
    logic       vm [6];
    logic [8:0] ve [6];
    vx = '{8'h0F, 8'hFF, 8'h80, 8'h07, 8'h05, 8'h00};
    vy = '{8'h01, 8'h01, 8'h80, 8'h05, 8'h07, 8'h00};
    vm = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
    ve = '{9'h010, 9'h100, 9'h100, 9'h102, 9'h0FE, 9'h100};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; x = vx[i]; y = vy[i]; mode = vm[i];
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL op%0d_early_valid: got %b expected 0", i, out_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_err++; $display("FAIL op%0d_valid: got %b expected 1", i, out_valid);
      end
      n_cmp++;
      if (sum !== ve[i]) begin
        n_err++; $display("FAIL op%0d_sum: got %h expected %h", i, sum, ve[i]);
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL op%0d_one_cycle: got %b expected 0", i, out_valid);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] vx [4];
    logic [7:0] vy [4];
    logic       vm [4];
    logic [8:0] ve [4];
    int tx = 0;
    int rx = 0;
    int stalls = 0;
    int cyc = 0;
    vx = '{8'h12, 8'hF0, 8'h40, 8'h99};
    vy = '{8'h34, 8'h20, 8'h41, 8'h11};
    vm = '{1'b0,  1'b0,  1'b1,  1'b1};
    ve = '{9'h046, 9'h110, 9'h0FF, 9'h188};
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; x = vx[0]; y = vy[0]; mode = vm[0];
    while (rx < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (out_valid && !out_ready) begin
        stalls++;
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_err++; $display("FAIL stall_in_ready: got %b expected 0", in_ready);
        end
        n_cmp++;
        if (sum !== ve[0]) begin
          n_err++; $display("FAIL stall_sum_hold: got %h expected %h", sum, ve[0]);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sum !== ve[rx]) begin
          n_err++; $display("FAIL stream_sum%0d: got %h expected %h", rx, sum, ve[rx]);
        end
        rx++;
      end
      if (in_valid && in_ready) tx++;
      @(posedge clk); #1;
      out_ready = (stalls >= 3);
      in_valid  = (tx < 4);
      if (tx < 4) begin
        x = vx[tx]; y = vy[tx]; mode = vm[tx];
      end
    end
    n_cmp++;
    if (rx !== 4) begin
      n_err++; $display("FAIL stream_count: got %0d results expected 4", rx);
    end
    n_cmp++;
    if (stalls !== 3) begin
      n_err++; $display("FAIL stall_cycles: got %0d expected 3", stalls);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_flush();
    @(posedge clk); #1;
    in_valid = 1'b1; x = 8'h10; y = 8'h20; mode = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (sum !== 9'h000) begin
      n_err++; $display("FAIL flush_sum: got %h expected 000", sum);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL flush_valid%0d: got %b expected 0", i, out_valid);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; x = 8'h21; y = 8'h12; mode = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL post_reset_valid: got %b expected 1", out_valid);
    end
    n_cmp++;
    if (sum !== 9'h033) begin
      n_err++; $display("FAIL post_reset_sum: got %h expected 033", sum);
    end
  endtask

  // Op t is accepted at the edge after it is driven; a DUT with S stages shows it
  // at the sample point S iterations later, on consecutive cycles.
  task automatic test_back_to_back();
    logic [8:0]  e8  [64];
    logic [32:0] e32 [64];
    for (int t = 0; t < 64 + 6; t++) begin
      @(posedge clk); #1;
      if (t < 64) begin
        bvalid = 1'b1;
        if (t == 0) begin
          bx = '1; by = 32'h1; bmode = 1'b0;
        end else if (t == 1) begin
          bx = '0; by = '0; bmode = 1'b1;
        end else begin
          bx = $urandom; by = $urandom; bmode = 1'($urandom_range(0, 1));
          if (t % 8 == 3) by[7:0] = bx[7:0];
        end
        e8[t]  = bmode ? {bx[7:0] >= by[7:0], 8'(bx[7:0] - by[7:0])}
                       : 9'(bx[7:0]) + 9'(by[7:0]);
        e32[t] = bmode ? {bx >= by, 32'(bx - by)} : 33'(bx) + 33'(by);
      end else begin
        bvalid = 1'b0;
      end
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        int idx;
        idx = t - (1 << g);
        n_cmp++;
        if (r8[g] !== 1'b1 || r32[g] !== 1'b1) begin
          n_err++; $display("FAIL b2b_ready_s%0d: got %b/%b expected 1/1", 1 << g, r8[g], r32[g]);
        end
        if (idx >= 0 && idx < 64) begin
          n_cmp++;
          if (v8[g] !== 1'b1 || s8[g] !== e8[idx]) begin
            n_err++;
            $display("FAIL b2b_w8_s%0d_op%0d: got v=%b sum=%h expected v=1 sum=%h",
                     1 << g, idx, v8[g], s8[g], e8[idx]);
          end
          n_cmp++;
          if (v32[g] !== 1'b1 || s32[g] !== e32[idx]) begin
            n_err++;
            $display("FAIL b2b_w32_s%0d_op%0d: got v=%b sum=%h expected v=1 sum=%h",
                     1 << g, idx, v32[g], s32[g], e32[idx]);
          end
        end else begin
          n_cmp++;
          if (v8[g] !== 1'b0 || v32[g] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle_s%0d_t%0d: got v=%b/%b expected 0/0", 1 << g, t, v8[g], v32[g]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_stall();
    test_reset_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
